// File: rtl/flash_cmd_sequencer_pkg.sv
// Shared types for the flash command sequencer: op encodings, FSM states
// and byte-select indices (index doubles as bit position in the Sel vector).
package flash_cmd_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_READ   = 2'b00,
        OP_PROG   = 2'b01,
        OP_SERASE = 2'b10,
        OP_CERASE = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_RDWIN,
        ST_WAITRDY,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        BYTE_DATA = 3'd0,
        BYTE_AA   = 3'd1,
        BYTE_55   = 3'd2,
        BYTE_B0   = 3'd3,
        BYTE_C0   = 3'd4,
        BYTE_D0   = 3'd5,
        BYTE_E0   = 3'd6,
        BYTE_00   = 3'd7
    } byteSel_t;

    localparam int STEP_W  = 3;
    localparam int NUM_SEL = 8;

    function automatic logic [NUM_SEL-1:0] byteToSel(input byteSel_t idx);
        logic [NUM_SEL-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/flash_cmd_sequencer_rom.sv
// Combinational command-sequence table: (op, step) -> byte to send and
// whether that step is the last byte of the sequence.
module flash_seq_rom
    import flash_cmd_sequencer_pkg::*;
(
    input  op_t               op,
    input  logic [STEP_W-1:0] step,
    output byteSel_t          byteIdx,
    output logic              lastStep
);

    // Steps outside a sequence's length are never reached; they fall back to a terminating AA.
    always_comb begin
        byteIdx  = BYTE_AA;
        lastStep = 1'b1;
        case (step)
            3'd0: begin
                byteIdx  = BYTE_AA;
                lastStep = 1'b0;
            end
            3'd1: begin
                byteIdx  = BYTE_55;
                lastStep = 1'b0;
            end
            3'd2: begin
                case (op)
                    OP_READ: begin
                        byteIdx  = BYTE_00;
                        lastStep = 1'b1;
                    end
                    OP_PROG: begin
                        byteIdx  = BYTE_B0;
                        lastStep = 1'b0;
                    end
                    default: begin
                        byteIdx  = BYTE_C0;
                        lastStep = 1'b0;
                    end
                endcase
            end
            3'd3: begin
                case (op)
                    OP_PROG: begin
                        byteIdx  = BYTE_DATA;
                        lastStep = 1'b1;
                    end
                    OP_SERASE, OP_CERASE: begin
                        byteIdx  = BYTE_AA;
                        lastStep = 1'b0;
                    end
                    default: begin
                        byteIdx  = BYTE_AA;
                        lastStep = 1'b1;
                    end
                endcase
            end
            3'd4: begin
                byteIdx  = BYTE_55;
                lastStep = 1'b0;
            end
            3'd5: begin
                byteIdx  = (op == OP_CERASE) ? BYTE_E0 : BYTE_D0;
                lastStep = 1'b1;
            end
            default: begin
                byteIdx  = BYTE_AA;
                lastStep = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/flash_cmd_sequencer.sv
// Flash command sequencer: walks the unlock/command byte sequence for the
// latched op, then opens a read window or waits for flash ready with timeout.
module flash_cmd_sequencer
    import flash_cmd_sequencer_pkg::*;
#(
    parameter int BYTE_CYCLES = 9,
    parameter int TIMEOUT     = 1023
) (
    input  logic       SCL,
    input  logic       Reset,
    input  logic       Start,
    input  logic [1:0] Op,
    input  logic       FlashRdy,
    output logic       SelData,
    output logic       SelAA,
    output logic       Sel55,
    output logic       SelB0,
    output logic       SelC0,
    output logic       SelD0,
    output logic       SelE0,
    output logic       Sel00,
    output logic       EnDataOut,
    output logic       EnDataIn,
    output logic       Busy,
    output logic       Done,
    output logic       Error
);

    localparam int CYC_W = $clog2(BYTE_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BYTE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    state_t               state;
    op_t                  opReg;
    logic [STEP_W-1:0]    step;
    logic [CYC_W-1:0]     cycleCnt;
    logic [TO_W-1:0]      toCnt;
    logic                 isLast;
    logic [NUM_SEL-1:0]   selVec;

    op_t                  romOp;
    logic [STEP_W-1:0]    romStep;
    byteSel_t             romByte;
    logic                 romLast;

    // The ROM looks one byte ahead so the Sel outputs can be loaded as registers.
    always_comb begin
        romOp   = opReg;
        romStep = step + STEP_W'(1);
        if (state == ST_IDLE) begin
            romOp   = op_t'(Op);
            romStep = '0;
        end
    end

    flash_seq_rom uRom (
        .op       (romOp),
        .step     (romStep),
        .byteIdx  (romByte),
        .lastStep (romLast)
    );

    always_ff @(posedge SCL or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            opReg     <= OP_READ;
            step      <= '0;
            cycleCnt  <= '0;
            toCnt     <= '0;
            isLast    <= 1'b0;
            selVec    <= '0;
            EnDataOut <= 1'b0;
            EnDataIn  <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Error     <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        opReg     <= op_t'(Op);
                        step      <= '0;
                        cycleCnt  <= '0;
                        toCnt     <= '0;
                        isLast    <= romLast;
                        selVec    <= byteToSel(romByte);
                        EnDataOut <= 1'b1;
                        Busy      <= 1'b1;
                        Error     <= 1'b0;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (cycleCnt == CYC_LAST) begin
                        cycleCnt <= '0;
                        if (isLast) begin
                            selVec    <= '0;
                            EnDataOut <= 1'b0;
                            if (opReg == OP_READ) begin
                                EnDataIn <= 1'b1;
                                state    <= ST_RDWIN;
                            end else begin
                                toCnt <= '0;
                                state <= ST_WAITRDY;
                            end
                        end else begin
                            step   <= step + STEP_W'(1);
                            isLast <= romLast;
                            selVec <= byteToSel(romByte);
                        end
                    end else begin
                        cycleCnt <= cycleCnt + CYC_W'(1);
                    end
                end
                ST_RDWIN: begin
                    if (cycleCnt == CYC_LAST) begin
                        cycleCnt <= '0;
                        EnDataIn <= 1'b0;
                        Done     <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        cycleCnt <= cycleCnt + CYC_W'(1);
                    end
                end
                // Ready is checked before the timeout so a late ready still counts as success.
                ST_WAITRDY: begin
                    if (FlashRdy) begin
                        toCnt <= '0;
                        Done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (toCnt == TO_LAST) begin
                        toCnt <= '0;
                        Error <= 1'b1;
                        Done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        toCnt <= toCnt + TO_W'(1);
                    end
                end
                ST_DONE: begin
                    Busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    selVec    <= '0;
                    EnDataOut <= 1'b0;
                    EnDataIn  <= 1'b0;
                    Busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign SelData = selVec[BYTE_DATA];
    assign SelAA   = selVec[BYTE_AA];
    assign Sel55   = selVec[BYTE_55];
    assign SelB0   = selVec[BYTE_B0];
    assign SelC0   = selVec[BYTE_C0];
    assign SelD0   = selVec[BYTE_D0];
    assign SelE0   = selVec[BYTE_E0];
    assign Sel00   = selVec[BYTE_00];

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Table-driven bench for flash_cmd_sequencer: each vector expands into a
// per-cycle expected output stream that is popped and compared every cycle.
module tb_flash_cmd_sequencer;

    localparam int BC    = 9;
    localparam int TO    = 15;
    localparam int NEVER = 100000;

    localparam logic [7:0] S_DATA = 8'h01;
    localparam logic [7:0] S_AA   = 8'h02;
    localparam logic [7:0] S_55   = 8'h04;
    localparam logic [7:0] S_B0   = 8'h08;
    localparam logic [7:0] S_C0   = 8'h10;
    localparam logic [7:0] S_D0   = 8'h20;
    localparam logic [7:0] S_E0   = 8'h40;
    localparam logic [7:0] S_00   = 8'h80;

    typedef struct packed {
        logic [7:0] sel;
        logic       enOut;
        logic       enIn;
        logic       busy;
        logic       done;
        logic       error;
    } outs_t;

    typedef struct packed {
        logic [1:0]      op;
        int              nBytes;
        logic [5:0][7:0] bytes;
        logic            isRead;
        int              rdyCycle;
        logic            noisy;
        int              abortAfter;
    } vec_t;

    logic       SCL = 1'b0;
    logic       Reset;
    logic       Start;
    logic [1:0] Op;
    logic       FlashRdy;
    logic       SelData, SelAA, Sel55, SelB0, SelC0, SelD0, SelE0, Sel00;
    logic       EnDataOut, EnDataIn, Busy, Done, Error;

    outs_t expQ[$];
    int    vectors     = 0;
    int    miscompares = 0;
    vec_t  vecs[11];

    flash_cmd_sequencer #(
        .BYTE_CYCLES (BC),
        .TIMEOUT     (TO)
    ) dut (
        .SCL       (SCL),
        .Reset     (Reset),
        .Start     (Start),
        .Op        (Op),
        .FlashRdy  (FlashRdy),
        .SelData   (SelData),
        .SelAA     (SelAA),
        .Sel55     (Sel55),
        .SelB0     (SelB0),
        .SelC0     (SelC0),
        .SelD0     (SelD0),
        .SelE0     (SelE0),
        .Sel00     (Sel00),
        .EnDataOut (EnDataOut),
        .EnDataIn  (EnDataIn),
        .Busy      (Busy),
        .Done      (Done),
        .Error     (Error)
    );

    always #5 SCL = ~SCL;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, want finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input logic [1:0] op, input int n,
                                   input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                   input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                                   input logic isRead, input int rdyCycle, input logic noisy,
                                   input int abortAfter);
        vec_t v;
        v.op         = op;
        v.nBytes     = n;
        v.bytes[0]   = b0;
        v.bytes[1]   = b1;
        v.bytes[2]   = b2;
        v.bytes[3]   = b3;
        v.bytes[4]   = b4;
        v.bytes[5]   = b5;
        v.isRead     = isRead;
        v.rdyCycle   = rdyCycle;
        v.noisy      = noisy;
        v.abortAfter = abortAfter;
        return v;
    endfunction

    task automatic checkOutput(input string name, input outs_t exp);
        outs_t act;
        act = {Sel00, SelE0, SelD0, SelC0, SelB0, Sel55, SelAA, SelData,
               EnDataOut, EnDataIn, Busy, Done, Error};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got sel=%b out=%b in=%b busy=%b done=%b err=%b, want sel=%b out=%b in=%b busy=%b done=%b err=%b",
                     name, act.sel, act.enOut, act.enIn, act.busy, act.done, act.error,
                     exp.sel, exp.enOut, exp.enIn, exp.busy, exp.done, exp.error);
        end
        vectors++;
        if (!$onehot0(act.sel) || (act.enOut && act.enIn)) begin
            miscompares++;
            $display("[TB] FAIL %s.invariant: got sel=%b out=%b in=%b, want one-hot/zero sel and exclusive enables",
                     name, act.sel, act.enOut, act.enIn);
        end
    endtask

    // rdyCycle: 0 = ready high throughout, NEVER = never ready, else the WAITRDY posedge that first sees ready.
    task automatic applyStimulus(input int vi, input vec_t v);
        outs_t e;
        int    wStart, r, wLen, doneIdx, rdyAt, total;
        logic  err;
        wStart = v.nBytes * BC;
        err    = 1'b0;
        rdyAt  = 2 * NEVER;
        for (int b = 0; b < v.nBytes; b++) begin
            for (int c = 0; c < BC; c++) begin
                e       = '0;
                e.sel   = v.bytes[b];
                e.enOut = 1'b1;
                e.busy  = 1'b1;
                expQ.push_back(e);
            end
        end
        if (v.isRead) begin
            for (int c = 0; c < BC; c++) begin
                e      = '0;
                e.enIn = 1'b1;
                e.busy = 1'b1;
                expQ.push_back(e);
            end
        end else begin
            if (v.rdyCycle == 0) begin
                r     = 1;
                rdyAt = 0;
            end else begin
                r     = v.rdyCycle;
                rdyAt = (r >= NEVER) ? 2 * NEVER : wStart + r;
            end
            wLen = (r <= TO) ? r : TO;
            err  = (r > TO);
            for (int c = 0; c < wLen; c++) begin
                e      = '0;
                e.busy = 1'b1;
                expQ.push_back(e);
            end
        end
        doneIdx = expQ.size();
        e       = '0;
        e.busy  = 1'b1;
        e.done  = 1'b1;
        e.error = err;
        expQ.push_back(e);
        e       = '0;
        e.error = err;
        expQ.push_back(e);
        expQ.push_back(e);
        total = expQ.size();

        Op       = v.op;
        Start    = 1'b1;
        FlashRdy = (rdyAt == 0);
        for (int i = 0; i < total; i++) begin
            @(posedge SCL);
            #1;
            checkOutput($sformatf("vec%0d.cyc%0d", vi, i), expQ.pop_front());
            if (i == v.abortAfter) begin
                expQ.delete();
                break;
            end
            Start = v.noisy && (i + 1 <= doneIdx + 1) &&
                    ((i + 1 == doneIdx + 1) || ($urandom_range(1, 0) == 1));
            if (v.noisy) Op = 2'($urandom_range(3, 0));
            FlashRdy = (i + 1 >= rdyAt);
        end
        Start = 1'b0;
    endtask

    task automatic resetMidOp(input int vi);
        #2;
        Reset = 1'b1;
        #1;
        checkOutput($sformatf("vec%0d.resetAsync", vi), '0);
        @(posedge SCL);
        #1;
        checkOutput($sformatf("vec%0d.resetHeld", vi), '0);
        Reset = 1'b0;
        @(posedge SCL);
        #1;
        checkOutput($sformatf("vec%0d.resetIdle", vi), '0);
    endtask

    initial begin
        vecs[0]  = mkVec(2'b00, 3, S_AA, S_55, S_00, 8'h00, 8'h00, 8'h00, 1'b1, NEVER, 1'b0, -1);
        vecs[1]  = mkVec(2'b01, 4, S_AA, S_55, S_B0, S_DATA, 8'h00, 8'h00, 1'b0, 6, 1'b0, -1);
        vecs[2]  = mkVec(2'b11, 6, S_AA, S_55, S_C0, S_AA, S_55, S_E0, 1'b0, NEVER, 1'b0, -1);
        vecs[3]  = mkVec(2'b00, 3, S_AA, S_55, S_00, 8'h00, 8'h00, 8'h00, 1'b1, NEVER, 1'b0, -1);
        vecs[4]  = mkVec(2'b10, 6, S_AA, S_55, S_C0, S_AA, S_55, S_D0, 1'b0, 0, 1'b0, -1);
        vecs[5]  = mkVec(2'b01, 4, S_AA, S_55, S_B0, S_DATA, 8'h00, 8'h00, 1'b0, TO, 1'b0, -1);
        vecs[6]  = mkVec(2'b10, 6, S_AA, S_55, S_C0, S_AA, S_55, S_D0, 1'b0, TO + 1, 1'b0, -1);
        vecs[7]  = mkVec(2'b00, 3, S_AA, S_55, S_00, 8'h00, 8'h00, 8'h00, 1'b1, NEVER, 1'b1, -1);
        vecs[8]  = mkVec(2'b11, 6, S_AA, S_55, S_C0, S_AA, S_55, S_E0, 1'b0, 3, 1'b1, -1);
        vecs[9]  = mkVec(2'b01, 4, S_AA, S_55, S_B0, S_DATA, 8'h00, 8'h00, 1'b0, 6, 1'b0, BC + 3);
        vecs[10] = mkVec(2'b00, 3, S_AA, S_55, S_00, 8'h00, 8'h00, 8'h00, 1'b1, NEVER, 1'b0, -1);

        Reset    = 1'b1;
        Start    = 1'b0;
        Op       = 2'b00;
        FlashRdy = 1'b0;
        @(posedge SCL);
        @(posedge SCL);
        #1;
        checkOutput("resetState", '0);
        Reset = 1'b0;
        @(posedge SCL);
        #1;
        checkOutput("idleAfterReset", '0);

        for (int vi = 0; vi < 11; vi++) begin
            applyStimulus(vi, vecs[vi]);
            if (vecs[vi].abortAfter >= 0) resetMidOp(vi);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
